// File: rtl/mips_operand_issue_pkg.sv
// Shared definitions for the MIPS operand-issue stage: opcode values, ALUOp
// encodings, the issued operand bundle and a sign-extension helper.
package mips_operand_issue_pkg;

  // Primary opcodes (instr[31:26]) that the stage understands.
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // ALUOp encodings consumed by the ALU control decoder.
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  // Operand bundle held in the output register.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  aluop;
    logic [5:0]  func;
    logic [4:0]  rd;
  } issue_bundle_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_operand_issue_regfile.sv
// mips_regfile: 32 x DATA_W register file, two combinational read ports,
// one synchronous write port, asynchronous active-low clear.
// Optional macro MIPS_ISSUE_WB_BYPASS_EN forwards a same-cycle write to reads.
module mips_regfile
  import mips_operand_issue_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [4:0]        i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic              i_we,
  input  logic [4:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);

  logic [DATA_W-1:0] r_mem [32];

  // Register storage; R0 is never written so it stays zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port A, R0 hard-wired to zero.
  always_comb begin
    o_rdata_a = (i_raddr_a == 5'd0) ? '0 : r_mem[i_raddr_a];
`ifdef MIPS_ISSUE_WB_BYPASS_EN
    if (i_we && (i_waddr != 5'd0) && (i_waddr == i_raddr_a)) begin
      o_rdata_a = i_wdata;
    end
`endif
  end

  // Read port B, R0 hard-wired to zero.
  always_comb begin
    o_rdata_b = (i_raddr_b == 5'd0) ? '0 : r_mem[i_raddr_b];
`ifdef MIPS_ISSUE_WB_BYPASS_EN
    if (i_we && (i_waddr != 5'd0) && (i_waddr == i_raddr_b)) begin
      o_rdata_b = i_wdata;
    end
`endif
  end

endmodule

// File: rtl/mips_operand_issue.sv
// mips_operand_issue: decodes a MIPS instruction, reads its source operands
// and holds the ALU operand bundle in a single valid/ready output stage.
// Optional macro MIPS_ISSUE_WB_BYPASS_EN enables write-back bypass on reads.
module mips_operand_issue
  import mips_operand_issue_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_A,
  output logic [DATA_W-1:0] out_B,
  output logic [1:0]        out_ALUOp,
  output logic [5:0]        out_FuncCode,
  output logic [4:0]        out_rd,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              illegal
);

  logic [5:0]        w_op;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;
  logic [DATA_W-1:0] w_imm_ext;
  logic              w_accept;
  logic              w_legal;
  issue_bundle_t     w_next;
  issue_bundle_t     r_bundle;
  logic              r_out_valid;
  logic              r_illegal;
  logic              unused_shamt;

  assign w_op      = in_instr[31:26];
  assign w_rs      = in_instr[25:21];
  assign w_rt      = in_instr[20:16];
  assign w_imm_ext = sign_ext16(in_instr[15:0]);
  // Shift amount is not an operand of any supported instruction.
  assign unused_shamt = ^in_instr[10:6];

  mips_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_raddr_a (w_rs),
    .o_rdata_a (w_rs_data),
    .i_raddr_b (w_rt),
    .o_rdata_b (w_rt_data),
    .i_we      (wb_en),
    .i_waddr   (wb_addr),
    .i_wdata   (wb_data)
  );

  // A held bundle blocks new input unless it is consumed this cycle.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Decode the offered instruction into the bundle it would issue.
  always_comb begin
    w_legal      = 1'b1;
    w_next.a     = w_rs_data;
    w_next.b     = w_rt_data;
    w_next.aluop = ALUOP_ADD;
    w_next.func  = 6'd0;
    w_next.rd    = 5'd0;
    case (w_op)
      OP_RTYPE: begin
        w_next.aluop = ALUOP_FUNC;
        w_next.func  = in_instr[5:0];
        w_next.rd    = in_instr[15:11];
      end
      OP_ADDI, OP_LW: begin
        w_next.b  = w_imm_ext;
        w_next.rd = w_rt;
      end
      OP_SW: begin
        w_next.b = w_imm_ext;
      end
      OP_BEQ: begin
        w_next.aluop = ALUOP_SUB;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // Output stage: load on accept, drop valid on consume, flag illegal opcodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_bundle    <= '0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      if (w_accept) begin
        // An illegal accept still retires any bundle consumed this cycle.
        r_out_valid <= w_legal;
        if (w_legal) begin
          r_bundle <= w_next;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign illegal      = r_illegal;
  assign out_A        = r_bundle.a;
  assign out_B        = r_bundle.b;
  assign out_ALUOp    = r_bundle.aluop;
  assign out_FuncCode = r_bundle.func;
  assign out_rd       = r_bundle.rd;

endmodule

// File: tb/tb_mips_operand_issue.sv
// Directed bench for mips_operand_issue with a scoreboard of expected bundles.
module tb_mips_operand_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_A;
  logic [31:0] out_B;
  logic [1:0]  out_ALUOp;
  logic [5:0]  out_FuncCode;
  logic [4:0]  out_rd;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;

  always #5 clk = ~clk;

  mips_operand_issue #(
    .DATA_W (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_A        (out_A),
    .out_B        (out_B),
    .out_ALUOp    (out_ALUOp),
    .out_FuncCode (out_FuncCode),
    .out_rd       (out_rd),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .illegal      (illegal)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  aluop;
    logic [5:0]  func;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_last;
  logic [31:0] m_regs[32];
  logic        m_ov;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Reference register read in the accepting cycle.
  function automatic logic [31:0] rd_model(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : m_regs[a];
`ifdef MIPS_ISSUE_WB_BYPASS_EN
    if (wb_en && (wb_addr == a) && (a != 5'd0)) v = wb_data;
`endif
    return v;
  endfunction

  task automatic drive(input logic v, input logic [31:0] instr, input logic rdy);
    in_valid  = v;
    in_instr  = instr;
    out_ready = rdy;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_en   = en;
    wb_addr = a;
    wb_data = d;
  endtask

  task automatic model_reset();
    m_ov = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    sb.delete();
  endtask

  // One clock: predict, step past the edge, then compare.
  task automatic cycle();
    logic       acc;
    logic       legal;
    logic       exp_ill;
    logic       nxt_ov;
    logic [5:0] op;
    exp_t       e;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, (!m_ov || out_ready)});
    acc     = in_valid && (!m_ov || out_ready);
    op      = in_instr[31:26];
    legal   = 1'b1;
    e.a     = rd_model(in_instr[25:21]);
    e.b     = rd_model(in_instr[20:16]);
    e.aluop = 2'b00;
    e.func  = 6'd0;
    e.rd    = 5'd0;
    if (op == 6'd0) begin
      e.aluop = 2'b10;
      e.func  = in_instr[5:0];
      e.rd    = in_instr[15:11];
    end else if (op == 6'd8 || op == 6'd35) begin
      e.b  = {{16{in_instr[15]}}, in_instr[15:0]};
      e.rd = in_instr[20:16];
    end else if (op == 6'd43) begin
      e.b = {{16{in_instr[15]}}, in_instr[15:0]};
    end else if (op == 6'd4) begin
      e.aluop = 2'b01;
    end else begin
      legal = 1'b0;
    end
    exp_ill = acc && !legal;
    if (acc) begin
      nxt_ov = legal;
      if (legal) sb.push_back(e);
    end else begin
      nxt_ov = out_ready ? 1'b0 : m_ov;
    end
    if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
    @(posedge clk);
    #1;
    m_ov = nxt_ov;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    check("illegal", {31'd0, illegal}, {31'd0, exp_ill});
    if (acc && legal) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'd0, 32'd1);
      end else begin
        m_last = sb.pop_front();
      end
    end
    if (m_ov) begin
      check("out_A", out_A, m_last.a);
      check("out_B", out_B, m_last.b);
      check("out_ALUOp", {30'd0, out_ALUOp}, {30'd0, m_last.aluop});
      check("out_FuncCode", {26'd0, out_FuncCode}, {26'd0, m_last.func});
      check("out_rd", {27'd0, out_rd}, {27'd0, m_last.rd});
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_A"}, out_A, 32'd0);
    check({tag, "_out_B"}, out_B, 32'd0);
    check({tag, "_ALUOp"}, {30'd0, out_ALUOp}, 32'd0);
    check({tag, "_FuncCode"}, {26'd0, out_FuncCode}, 32'd0);
    check({tag, "_out_rd"}, {27'd0, out_rd}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b1);
    set_wb(1'b0, 5'd0, 32'd0);
    model_reset();
    #3;
    check_reset_state("por");
    #9;
    rst_n = 1'b1;

    // Load R5=7, R6=3.
    set_wb(1'b1, 5'd5, 32'h0000_0007);
    cycle();
    set_wb(1'b1, 5'd6, 32'h0000_0003);
    cycle();
    set_wb(1'b0, 5'd0, 32'd0);

    // sub rd=7, rs=5, rt=6 then back-to-back I-types and beq.
    drive(1'b1, enc_r(5'd5, 5'd6, 5'd7, 6'd34), 1'b1);
    cycle();
    drive(1'b1, enc_i(6'd8, 5'd5, 5'd9, 16'hFFFF), 1'b1);
    cycle();
    drive(1'b1, enc_i(6'd35, 5'd6, 5'd10, 16'h0010), 1'b1);
    cycle();
    drive(1'b1, enc_i(6'd43, 5'd5, 5'd11, 16'h8000), 1'b1);
    cycle();
    drive(1'b1, enc_i(6'd4, 5'd5, 5'd6, 16'h0004), 1'b1);
    cycle();

    // Backpressure: hold the add bundle for three cycles, then release.
    drive(1'b1, enc_r(5'd6, 5'd5, 5'd8, 6'd32), 1'b1);
    cycle();
    drive(1'b1, enc_i(6'd8, 5'd6, 5'd12, 16'h0005), 1'b0);
    cycle();
    cycle();
    cycle();
    drive(1'b1, enc_i(6'd8, 5'd6, 5'd12, 16'h0005), 1'b1);
    cycle();
    drive(1'b0, 32'd0, 1'b1);
    cycle();

    // Same-cycle write-back to R5 while reading it.
    set_wb(1'b1, 5'd5, 32'hA5A5_A5A5);
    drive(1'b1, enc_r(5'd5, 5'd6, 5'd13, 6'd32), 1'b1);
    cycle();
    set_wb(1'b0, 5'd0, 32'd0);
    drive(1'b1, enc_r(5'd5, 5'd6, 5'd13, 6'd32), 1'b1);
    cycle();

    // Illegal opcode: one-cycle pulse, no bundle.
    drive(1'b1, enc_i(6'd63, 5'd5, 5'd6, 16'h1234), 1'b1);
    cycle();
    drive(1'b0, 32'd0, 1'b1);
    cycle();
    cycle();

    // Writes to R0 are dropped.
    set_wb(1'b1, 5'd0, 32'hDEAD_BEEF);
    cycle();
    set_wb(1'b0, 5'd0, 32'd0);
    drive(1'b1, enc_r(5'd0, 5'd0, 5'd1, 6'd32), 1'b1);
    cycle();

    // Asynchronous reset while a bundle is held.
    drive(1'b1, enc_r(5'd5, 5'd6, 5'd14, 6'd32), 1'b1);
    cycle();
    drive(1'b0, 32'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid");
    check("mid_r5", dut.u_regfile.r_mem[5], 32'd0);
    check("mid_r6", dut.u_regfile.r_mem[6], 32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    drive(1'b1, enc_r(5'd5, 5'd6, 5'd14, 6'd32), 1'b1);
    cycle();
    drive(1'b0, 32'd0, 1'b1);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_operand_issue.md
MIPS_OPERAND_ISSUE -- requirements
Module: mips_operand_issue

Interface
REQ-001 Parameter: DATA_W, 32, operand and register width; only 32 is supported.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  instruction word offered upstream.
REQ-005 Port: in_ready  output  1  stage accepts in_instr this cycle.
REQ-006 Port: in_instr  input  32  MIPS instruction word.
REQ-007 Port: out_valid  output  1  operand bundle held for the ALU stage.
REQ-008 Port: out_ready  input  1  ALU stage consumes the bundle this cycle.
REQ-009 Port: out_A, out_B  output  32 each  ALU operands A and B.
REQ-010 Port: out_ALUOp  output  2  ALUOp to the ALU control decoder.
REQ-011 Port: out_FuncCode  output  6  FuncCode to the ALU control decoder.
REQ-012 Port: out_rd  output  5  destination register; 0 means no write.
REQ-013 Port: wb_en, wb_addr, wb_data  input  1/5/32  register-file write-back port.
REQ-014 Port: illegal  output  1  one-cycle pulse when an unsupported opcode is accepted.

Function
REQ-015 Handshakes SHALL work as follows:
- a transfer occurs on a cycle with valid and ready both high;
- in_ready = !out_valid || out_ready;
- the output register is a single stage, so one accepted input can be issued back-to-back every cycle.
REQ-016 Latency SHALL be one cycle: a bundle accepted at edge N is visible on the outputs after edge N and held stable while out_valid && !out_ready.
REQ-017 Opcode instr[31:26]=0 (R-type) SHALL issue:
- A=R[rs], B=R[rt];
- ALUOp=2'b10, FuncCode=instr[5:0];
- rd=instr[15:11].
REQ-018 Opcode 8 (addi) SHALL issue:
- A=R[rs], B=sign-extended instr[15:0];
- ALUOp=2'b00, FuncCode=0;
- rd=instr[20:16].
REQ-019 Opcodes 35 (lw) and 43 (sw) SHALL issue:
- A=R[rs], B=sign-extended imm, ALUOp=2'b00;
- rd=instr[20:16] for lw, rd=0 for sw.
REQ-020 Opcode 4 (beq) SHALL issue A=R[rs], B=R[rt], ALUOp=2'b01, rd=0.
REQ-021 Any other opcode SHALL be consumed (in_ready honoured), SHALL NOT set out_valid, and SHALL pulse illegal for the cycle after acceptance.
REQ-022 Register 0 SHALL always read 0; writes with wb_addr=0 SHALL be ignored.
REQ-023 Write-back SHALL update R[wb_addr] at the clock edge when wb_en=1, independent of both handshakes.
REQ-024 When out_valid is high, an accept with in_valid low SHALL NOT occur: out_ready alone SHALL clear out_valid at the edge.

Reset
REQ-025 While rst_n=0, the following SHALL be cleared immediately:
- out_valid=0, illegal=0;
- out_A, out_B, out_ALUOp, out_FuncCode, out_rd all 0;
- all 32 registers 0.
REQ-026 Reset asserted mid-transfer SHALL discard the held bundle; in_ready SHALL read 1 during reset.

Configuration
REQ-027 Macro MIPS_ISSUE_WB_BYPASS_EN controls same-cycle write-back bypass:
- defined: a read of R[x] in the accepting cycle with wb_en=1, wb_addr=x, x≠0 SHALL return wb_data;
- undefined: the read SHALL return the pre-write value, and upstream is responsible for stalling.

Structure
REQ-028 A shared package SHALL hold the opcode constants (RTYPE=0, BEQ=4, ADDI=8, LW=35, SW=43) and the ALUOp encodings (2'b00, 2'b01, 2'b10).
REQ-029 The register file SHALL be a sub-module, mips_regfile: 32x32, two combinational read ports, one synchronous write port, asynchronous active-low clear.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Write R5=0x00000007, R6=0x00000003; accept R-type sub rd=7 (func 34) -> out_A=7, out_B=3, ALUOp=2'b10, FuncCode=34, out_rd=7, one cycle later.
- addi rt=9, rs=5, imm=0xFFFF -> out_B=0xFFFFFFFF, ALUOp=2'b00, out_rd=9.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; release -> next instruction issues on the following edge.
- Accept a read of R5 while wb_en=1, wb_addr=5, wb_data=0xA5A5A5A5 -> out_A=0xA5A5A5A5 with the macro defined, prior value without it.
- Opcode 63 accepted -> illegal pulses for exactly 1 cycle, out_valid stays 0; write to R0 -> R0 still reads 0.
- Drop rst_n while out_valid=1 -> out_valid=0 and all registers 0 immediately.
